// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, saturation limits, FSM encoding and ReLU helper
package nn_pkg;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x, input bit en);
    return (en && x[DATA_W-1]) ? '0 : x;
  endfunction
endpackage

// File: rtl/neuron_accumulator_if.sv
// neuron_accumulator_if: start/bias, product stream and result handshake bundle
interface neuron_accumulator_if;
  import nn_pkg::*;
  logic              start;
  logic [DATA_W-1:0] bias;
  logic              prod_valid;
  logic              prod_ready;
  logic [DATA_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              sat_flag;
  modport master (
    output start, bias, prod_valid, prod, out_ready,
    input  prod_ready, out_valid, out_data, busy, sat_flag
  );
  modport slave (
    input  start, bias, prod_valid, prod, out_ready,
    output prod_ready, out_valid, out_data, busy, sat_flag
  );
endinterface

// File: rtl/sat_add.sv
// sat_add: signed 32-bit adder clamping to SAT_MAX/SAT_MIN with overflow flag
module sat_add
  import nn_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              sat
);
  logic [DATA_W:0] s;
  assign s   = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  // overflow iff the sign-extension bit disagrees with the 32-bit sign
  assign sat = s[DATA_W] ^ s[DATA_W-1];
  assign sum = !sat ? s[DATA_W-1:0] : s[DATA_W] ? SAT_MIN : SAT_MAX;
endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: saturating sum of N_INPUTS products plus bias, optional ReLU
module neuron_accumulator
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 784,
  parameter bit RELU_EN  = 1
) (
  input logic clk,
  input logic rst_n,
  neuron_accumulator_if.slave io
);
  localparam logic [15:0] LAST = 16'(N_INPUTS - 1);
  state_t            state_q;
  logic [DATA_W-1:0] acc_q, bias_q, out_q, add_b, add_sum;
  logic [15:0]       cnt_q;
  logic              sat_q, add_sat;
  // one adder serves both the product stream and the final bias step
  assign add_b = (state_q == BIAS) ? bias_q : io.prod;
  sat_add u_add (.a(acc_q), .b(add_b), .sum(add_sum), .sat(add_sat));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      bias_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (io.start) begin
          acc_q   <= '0;
          cnt_q   <= '0;
          sat_q   <= 1'b0;
          bias_q  <= io.bias;
          state_q <= ACCUM;
        end
        ACCUM: if (io.prod_valid) begin
          acc_q   <= add_sum;
          cnt_q   <= cnt_q + 16'd1;
          sat_q   <= sat_q | add_sat;
          if (cnt_q == LAST) state_q <= BIAS;
        end
        BIAS: begin
          acc_q   <= add_sum;
          sat_q   <= sat_q | add_sat;
          out_q   <= relu(add_sum, RELU_EN);
          state_q <= OUT;
        end
        OUT: if (io.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign io.prod_ready = state_q == ACCUM;
  assign io.out_valid  = state_q == OUT;
  assign io.busy       = state_q != IDLE;
  assign io.out_data   = out_q;
  assign io.sat_flag   = sat_q;
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: directed scenarios on N=4, N=2 (ReLU on/off) and N=1 instances
module tb_neuron_accumulator;
  logic clk, rst_n;
  int checks = 0, errors = 0, hs_a = 0, hs_b = 0;
  neuron_accumulator_if ia();
  neuron_accumulator_if ib();
  neuron_accumulator_if ic();
  neuron_accumulator_if id();
  assign ic.start = ib.start;
  assign ic.bias = ib.bias;
  assign ic.prod_valid = ib.prod_valid;
  assign ic.prod = ib.prod;
  assign ic.out_ready = ib.out_ready;
  assign id.start = ib.start;
  assign id.bias = ib.bias;
  assign id.prod_valid = ib.prod_valid;
  assign id.prod = ib.prod;
  assign id.out_ready = ib.out_ready;
  neuron_accumulator #(.N_INPUTS(4), .RELU_EN(1)) dut_a (.clk(clk), .rst_n(rst_n), .io(ia));
  neuron_accumulator #(.N_INPUTS(2), .RELU_EN(1)) dut_b (.clk(clk), .rst_n(rst_n), .io(ib));
  neuron_accumulator #(.N_INPUTS(2), .RELU_EN(0)) dut_c (.clk(clk), .rst_n(rst_n), .io(ic));
  neuron_accumulator #(.N_INPUTS(1), .RELU_EN(1)) dut_d (.clk(clk), .rst_n(rst_n), .io(id));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ia.out_valid && ia.out_ready) hs_a <= hs_a + 1;
    if (ib.out_valid && ib.out_ready) hs_b <= hs_b + 1;
  end

  task automatic test_reset;
    rst_n = 0;
    #1;
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", ia.busy); end
    checks++; if (ia.prod_ready !== 1'b0) begin errors++; $display("FAIL rst_prod_ready: got %b want 0", ia.prod_ready); end
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", ia.out_valid); end
    checks++; if (ia.out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data: got %h want 0", ia.out_data); end
    checks++; if (ia.sat_flag !== 1'b0) begin errors++; $display("FAIL rst_sat: got %b want 0", ia.sat_flag); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL rst_wait_idle: got %b want 0", ia.busy); end
  endtask

  task automatic test_basic;
    ia.out_ready = 1; ia.start = 1; ia.bias = 32'd5;
    @(negedge clk);
    ia.start = 0;
    checks++; if (ia.prod_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", ia.prod_ready); end
    for (int i = 1; i <= 4; i++) begin ia.prod_valid = 1; ia.prod = 32'(i); @(negedge clk); end
    ia.prod_valid = 0;
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: got %b want 0", ia.out_valid); end
    checks++; if (ia.prod_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_bias: got %b want 0", ia.prod_ready); end
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL basic_lat2: got %b want 1", ia.out_valid); end
    checks++; if (ia.out_data !== 32'd15) begin errors++; $display("FAIL basic_data: got %h want %h", ia.out_data, 32'd15); end
    checks++; if (ia.sat_flag !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b want 0", ia.sat_flag); end
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b0 || ia.busy !== 1'b0) begin errors++; $display("FAIL basic_release: got valid %b busy %b want 0 0", ia.out_valid, ia.busy); end
  endtask

  task automatic test_saturate;
    ib.out_ready = 1; ib.start = 1; ib.bias = 32'd0;
    @(negedge clk);
    ib.start = 0; ib.prod_valid = 1; ib.prod = 32'h7FFF_FFF0;
    @(negedge clk);
    ib.prod = 32'h100;
    @(negedge clk);
    ib.prod_valid = 0;
    checks++; if (id.out_valid !== 1'b1 || id.out_data !== 32'h7FFF_FFF0) begin errors++; $display("FAIL n1_out: got valid %b data %h want 1 7ffffff0", id.out_valid, id.out_data); end
    checks++; if (id.sat_flag !== 1'b0) begin errors++; $display("FAIL n1_sat: got %b want 0", id.sat_flag); end
    @(negedge clk);
    checks++; if (ib.out_valid !== 1'b1 || ib.out_data !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_data: got valid %b data %h want 1 7fffffff", ib.out_valid, ib.out_data); end
    checks++; if (ib.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", ib.sat_flag); end
    checks++; if (ic.out_data !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_norelu: got %h want 7fffffff", ic.out_data); end
    @(negedge clk);
    checks++; if (ib.busy !== 1'b0 || ib.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_sticky: got busy %b sat %b want 0 1", ib.busy, ib.sat_flag); end
  endtask

  task automatic test_relu;
    ib.out_ready = 1; ib.start = 1; ib.bias = 32'hFFFF_FFF6;
    @(negedge clk);
    ib.start = 0;
    checks++; if (ib.sat_flag !== 1'b0) begin errors++; $display("FAIL relu_sat_clear: got %b want 0", ib.sat_flag); end
    ib.prod_valid = 1; ib.prod = 32'd2;
    @(negedge clk);
    ib.prod = 32'd3;
    @(negedge clk);
    ib.prod_valid = 0;
    @(negedge clk);
    checks++; if (ib.out_valid !== 1'b1 || ib.out_data !== 32'd0) begin errors++; $display("FAIL relu_on: got valid %b data %h want 1 0", ib.out_valid, ib.out_data); end
    checks++; if (ic.out_valid !== 1'b1 || ic.out_data !== 32'hFFFF_FFFB) begin errors++; $display("FAIL relu_off: got valid %b data %h want 1 fffffffb", ic.out_valid, ic.out_data); end
    @(negedge clk);
  endtask

  task automatic test_stall;
    logic [5:0] v;
    int p [6];
    v = 6'b111001;
    p = '{10, 1000, 1000, 20, 30, 40};
    ia.out_ready = 0; ia.start = 1; ia.bias = 32'd0;
    @(negedge clk);
    ia.start = 0;
    for (int i = 0; i < 6; i++) begin
      ia.prod_valid = v[i]; ia.prod = 32'(p[i]);
      @(negedge clk);
      if (i == 2) begin
        checks++; if (ia.prod_ready !== 1'b1 || ia.out_valid !== 1'b0) begin errors++; $display("FAIL stall_gap: got ready %b valid %b want 1 0", ia.prod_ready, ia.out_valid); end
      end
    end
    ia.prod_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ia.out_valid !== 1'b1 || ia.out_data !== 32'd100) begin errors++; $display("FAIL stall_hold%0d: got valid %b data %h want 1 %h", i, ia.out_valid, ia.out_data, 32'd100); end
      @(negedge clk);
    end
    ia.out_ready = 1;
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", ia.out_valid); end
  endtask

  task automatic test_reset_mid;
    ia.out_ready = 1; ia.start = 1; ia.bias = 32'd7;
    @(negedge clk);
    ia.start = 0;
    for (int i = 0; i < 2; i++) begin ia.prod_valid = 1; ia.prod = 32'd50; @(negedge clk); end
    ia.prod_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (ia.busy !== 1'b0 || ia.out_data !== 32'd0) begin errors++; $display("FAIL mid_async: got busy %b data %h want 0 0", ia.busy, ia.out_data); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ia.out_valid !== 1'b0 || ia.busy !== 1'b0) begin errors++; $display("FAIL mid_no_out%0d: got valid %b busy %b want 0 0", i, ia.out_valid, ia.busy); end
    end
    ia.start = 1; ia.bias = 32'd0;
    @(negedge clk);
    ia.start = 0;
    for (int i = 0; i < 4; i++) begin ia.prod_valid = 1; ia.prod = 32'd1; @(negedge clk); end
    ia.prod_valid = 0;
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b1 || ia.out_data !== 32'd4) begin errors++; $display("FAIL mid_fresh: got valid %b data %h want 1 4", ia.out_valid, ia.out_data); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    ia.out_ready = 0; ia.start = 1; ia.bias = 32'd3;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      ia.start = (i <= 2); ia.bias = 32'd99; ia.prod_valid = 1; ia.prod = 32'(i);
      @(negedge clk);
    end
    ia.start = 0; ia.prod_valid = 0;
    @(negedge clk);
    checks++; if (ia.out_valid !== 1'b1 || ia.out_data !== 32'd13) begin errors++; $display("FAIL ign_data: got valid %b data %h want 1 %h", ia.out_valid, ia.out_data, 32'd13); end
    ia.start = 1; ia.bias = 32'd50; ia.out_ready = 1;
    @(negedge clk);
    ia.start = 0;
    checks++; if (ia.busy !== 1'b0 || ia.out_valid !== 1'b0) begin errors++; $display("FAIL ign_out_start: got busy %b valid %b want 0 0", ia.busy, ia.out_valid); end
    @(negedge clk);
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL ign_stay_idle: got %b want 0", ia.busy); end
    checks++; if (hs_a !== 4) begin errors++; $display("FAIL hs_count_a: got %0d want 4", hs_a); end
    checks++; if (hs_b !== 2) begin errors++; $display("FAIL hs_count_b: got %0d want 2", hs_b); end
  endtask

  initial begin
    ia.start = 0; ia.bias = 0; ia.prod_valid = 0; ia.prod = 0; ia.out_ready = 0;
    ib.start = 0; ib.bias = 0; ib.prod_valid = 0; ib.prod = 0; ib.out_ready = 0;
    test_reset;
    test_basic;
    test_saturate;
    test_relu;
    test_stall;
    test_reset_mid;
    test_start_ignored;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter N_INPUTS, default 784, the number of products summed per neuron (legal range 1..65535).
REQ-002 SHALL have parameter RELU_EN, default 1: 1 applies ReLU to the output, 0 passes the biased sum unchanged.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a new neuron; sampled only in IDLE.
REQ-006 SHALL have port bias  input  32  signed bias; captured on the cycle start is accepted.
REQ-007 SHALL have port prod_valid  input  1  upstream multiplier product valid.
REQ-008 SHALL have port prod_ready  output  1  block accepts a product this cycle.
REQ-009 SHALL have port prod  input  32  signed, already-saturated product from the multiplier stage.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port out_data  output  32  signed neuron activation.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port sat_flag  output  1  sticky; set if any addition for the current neuron saturated.

Function
REQ-015 SHALL implement states IDLE, ACCUM, BIAS and OUT.
REQ-016 IDLE: start=1 SHALL clear acc, cnt and sat_flag, capture bias and go to ACCUM on the next edge.
REQ-017 ACCUM: prod_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-018 ACCUM: each cycle with prod_valid&&prod_ready SHALL set acc <= sat_add(acc, prod) and cnt <= cnt+1.
REQ-019 ACCUM: prod_valid=0 SHALL leave acc and cnt unchanged, with no timeout.
REQ-020 The handshake with cnt==N_INPUTS-1 SHALL move to BIAS.
REQ-021 BIAS: the block SHALL set acc <= sat_add(acc, captured bias) in one cycle, then go to OUT.
REQ-022 OUT: out_valid=1; out_data = (RELU_EN && acc[31]) ? 0 : acc, held stable until out_ready.
REQ-023 out_valid&&out_ready SHALL return the block to IDLE; out_valid deasserts on the next cycle.
REQ-024 Minimum latency SHALL be out_valid asserted 2 cycles after the edge accepting the last product.
REQ-025 sat_add: a 33-bit signed sum above 32'h7FFF_FFFF SHALL yield 32'h7FFF_FFFF; below 32'h8000_0000 it SHALL yield 32'h8000_0000; sat_flag SHALL set on either case.
REQ-026 start outside IDLE SHALL be ignored; bias and acc SHALL be unaffected.
REQ-027 start together with out_ready in OUT SHALL NOT start a new neuron; start is sampled again in IDLE.
REQ-028 N_INPUTS=1 SHALL go to BIAS after a single handshake.
REQ-029 cnt SHALL be 16 bits and SHALL never wrap within one neuron.
REQ-030 sat_flag SHALL hold its value through OUT and clear only on the next accepted start.

Reset
REQ-031 rst_n=0 SHALL force state=IDLE, acc=0, cnt=0, bias register=0, sat_flag=0, out_valid=0, prod_ready=0 and out_data=0 immediately, independent of clk.
REQ-032 Reset asserted mid-neuron (ACCUM, BIAS or OUT) SHALL discard the partial sum; no out_valid SHALL follow.
REQ-033 After reset deassertion the block SHALL wait in IDLE for start.

Structure
REQ-034 Shared package nn_pkg SHALL hold SAT_MAX=32'h7FFF_FFFF, SAT_MIN=32'h8000_0000, the state encoding and DATA_W=32.
REQ-035 The saturating adder SHALL be one combinational sub-module sat_add (a, b, sum, sat), reused by the ACCUM and BIAS paths.
REQ-036 Target size SHALL be roughly 150-250 RTL lines total.

Verification
REQ-037 N_INPUTS=4, bias=5, products 1,2,3,4 back-to-back, out_ready=1 -> out_data=15, sat_flag=0, out_valid 2 cycles after the 4th accept.
REQ-038 N_INPUTS=2, bias=0, products 32'h7FFF_FFF0 and 32'h100 -> out_data=32'h7FFF_FFFF, sat_flag=1.
REQ-039 RELU_EN=1, N_INPUTS=2, bias=-10, products 2,3 -> out_data=0; with RELU_EN=0 -> out_data=32'hFFFF_FFFB.
REQ-040 prod_valid toggled 1,0,0,1,1 with out_ready held 0 for 3 cycles -> acc is unchanged in the gaps; out_data stays stable; one result per neuron.
REQ-041 rst_n pulsed low after 2 of 4 products, then a new start with products 1,1,1,1 and bias 0 -> out_data=4, with no stale value.
REQ-042 start pulsed during ACCUM and during OUT -> ignored; a single out_valid handshake per start accepted in IDLE.
